// File: rtl/wb_tg_pkg.sv
// Shared definitions for the Wishbone traffic generator.
//   wb_tg_state_e : sequencing FSM states
//   LFSR_POLY     : Galois feedback mask (right-shifting form)
//   LFSR_RESET    : LFSR value after reset, and the substitute for a zero seed
//   lfsr_next()   : one LFSR step, shared by the LFSR block and the draw logic
package wb_tg_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_WR   = 3'd2,
        S_RD   = 3'd3,
        S_WAIT = 3'd4,
        S_GAP  = 3'd5,
        S_DONE = 3'd6
    } wb_tg_state_e;

    localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;
    localparam logic [31:0] LFSR_RESET = 32'h0000_0001;

    // Right-shift Galois step: the bit leaving at position 0 decides
    // whether the feedback mask is applied.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/wb_tg_lfsr32.sv
// 32-bit Galois LFSR holding the generator's random state.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous reset, active-high (state -> LFSR_RESET)
//   load_i  : load seed_i (zero seed is replaced by LFSR_RESET)
//   step_i  : consume one transaction's draws (address draw, then data draw)
//   seed_i  : seed value
//   value_o : current state; the next two steps are the pending draws
module wb_tg_lfsr32
    import wb_tg_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [31:0] seed_i,
    output logic [31:0] value_o
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    // A transaction takes two draws (address, data), so one step_i
    // advances the register by two single steps.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (seed_i == 32'h0) ? LFSR_RESET : seed_i;
        end else if (step_i) begin
            lfsr_d = lfsr_next(lfsr_next(lfsr_q));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_RESET;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/wb_traffic_gen.sv
// Wishbone classic master issuing NUM_TXN pseudo-random writes into a
// 2**WIN_LOG2-word window from address 0, optionally reading each one back
// and comparing. Every transfer has an ack timeout; err/timeout/mismatch
// events are tallied in saturating counters.
// Ports:
//   wb_clk_i, wb_rst_i        : clock, synchronous active-high reset
//   start_i, rdback_i, seed_i : run control, sampled when a start is accepted
//   wb_adr_o .. wb_stb_o      : Wishbone master outputs (all registered)
//   wb_dat_i, wb_ack_i, wb_err_i : Wishbone slave responses
//   busy_o, done_o            : run status
//   txn_cnt_o, err_cnt_o, tmo_cnt_o, mis_cnt_o : status counters
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | after reset, waiting for start_i
// LOAD   | seed loaded, counters cleared, busy raised
// WR     | draw address/data, raise a write cycle on the next edge
// RD     | raise a read cycle of the address just written
// WAIT   | cycle open; wait for err/ack or timeout, then drop it
// GAP    | idle spacing between transactions
// DONE   | NUM_TXN transactions finished; done_o held, start_i restarts
module wb_traffic_gen
    import wb_tg_pkg::*;
#(
    parameter int DW       = 32,
    parameter int AW       = 10,
    parameter int WIN_LOG2 = 6,
    parameter int NUM_TXN  = 60,
    parameter int TIMEOUT  = 40,
    parameter int GAP      = 1,
    parameter int CW       = 16
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            start_i,
    input  logic            rdback_i,
    input  logic [31:0]     seed_i,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic            wb_we_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [CW-1:0]   txn_cnt_o,
    output logic [CW-1:0]   err_cnt_o,
    output logic [CW-1:0]   tmo_cnt_o,
    output logic [CW-1:0]   mis_cnt_o
);

    localparam int SW = DW / 8;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP + 2);
    localparam int PW = $clog2(NUM_TXN + 1);

    localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LOAD  = (GAP > 0) ? GW'(GAP - 1) : '0;
    localparam logic [PW-1:0] PAIR_ALL  = PW'(NUM_TXN);
    localparam logic [PW-1:0] PAIR_LAST = PW'(NUM_TXN - 1);

    wb_tg_state_e state_q, state_d;

    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rdback_q, rdback_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [PW-1:0] pair_q, pair_d;
    logic [CW-1:0] txn_q, txn_d;
    logic [CW-1:0] errc_q, errc_d;
    logic [CW-1:0] tmoc_q, tmoc_d;
    logic [CW-1:0] misc_q, misc_d;

    logic [31:0] lfsr_val;
    logic [31:0] draw_a;
    logic [31:0] draw_d;
    logic        lfsr_step;
    logic        start_ok;
    logic        in_wait;
    logic        tmo_hit;
    logic        xfer_end;
    logic        go_read;
    logic        pair_end;
    logic        pair_last;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Write data is the data draw, repeated every 32 bits for wide buses.
    function automatic logic [DW-1:0] rep_data(input logic [31:0] d);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DW; i++) begin
            r[i] = d[i % 32];
        end
        return r;
    endfunction

    wb_tg_lfsr32 u_lfsr (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .load_i  (start_ok),
        .step_i  (lfsr_step),
        .seed_i  (seed_i),
        .value_o (lfsr_val)
    );

    assign draw_a = lfsr_next(lfsr_val);
    assign draw_d = lfsr_next(draw_a);

    assign start_ok = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Responses only count inside WAIT; err beats ack, and either beats
    // a timeout expiring in the same cycle.
    assign in_wait   = (state_q == S_WAIT);
    assign tmo_hit   = !wb_ack_i && !wb_err_i && (tmo_q == '0);
    assign xfer_end  = in_wait && (wb_ack_i || wb_err_i || (tmo_q == '0));
    assign go_read   = we_q && wb_ack_i && !wb_err_i && rdback_q;
    assign pair_end  = xfer_end && !go_read;
    assign pair_last = (pair_q == PAIR_LAST);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) state_d = S_LOAD;
            end
            S_LOAD: state_d = S_WR;
            S_WR, S_RD: state_d = S_WAIT;
            S_WAIT: begin
                if (xfer_end) begin
                    if (go_read)        state_d = S_RD;
                    else if (GAP > 0)   state_d = S_GAP;
                    else if (pair_last) state_d = S_DONE;
                    else                state_d = S_WR;
                end
            end
            S_GAP: begin
                if (gap_q == '0) state_d = (pair_q == PAIR_ALL) ? S_DONE : S_WR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cyc_d     = cyc_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        busy_d    = busy_q;
        done_d    = done_q;
        rdback_d  = rdback_q;
        tmo_d     = tmo_q;
        gap_d     = gap_q;
        pair_d    = pair_q;
        txn_d     = txn_q;
        errc_d    = errc_q;
        tmoc_d    = tmoc_q;
        misc_d    = misc_q;
        lfsr_step = 1'b0;

        if (start_ok) begin
            busy_d   = 1'b1;
            done_d   = 1'b0;
            rdback_d = rdback_i;
            pair_d   = '0;
            txn_d    = '0;
            errc_d   = '0;
            tmoc_d   = '0;
            misc_d   = '0;
        end

        unique case (state_q)
            S_WR: begin
                adr_d                 = '0;
                adr_d[WIN_LOG2-1:0]   = draw_a[WIN_LOG2-1:0];
                dat_d                 = rep_data(draw_d);
                we_d                  = 1'b1;
                cyc_d                 = 1'b1;
                tmo_d                 = TMO_LOAD;
                lfsr_step             = 1'b1;
            end
            S_RD: begin
                we_d  = 1'b0;
                cyc_d = 1'b1;
                tmo_d = TMO_LOAD;
            end
            S_WAIT: begin
                if (xfer_end) begin
                    cyc_d = 1'b0;
                    we_d  = 1'b0;
                    if (wb_err_i) begin
                        errc_d = sat_inc(errc_q);
                    end else if (wb_ack_i) begin
                        if (!we_q && (wb_dat_i != dat_q)) misc_d = sat_inc(misc_q);
                    end else if (tmo_hit) begin
                        tmoc_d = sat_inc(tmoc_q);
                    end
                    if (pair_end) begin
                        txn_d  = sat_inc(txn_q);
                        pair_d = pair_q + 1'b1;
                        gap_d  = GAP_LOAD;
                        if ((GAP == 0) && pair_last) begin
                            busy_d = 1'b0;
                            done_d = 1'b1;
                        end
                    end
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    if (pair_q == PAIR_ALL) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rdback_q <= 1'b0;
            tmo_q    <= '0;
            gap_q    <= '0;
            pair_q   <= '0;
            txn_q    <= '0;
            errc_q   <= '0;
            tmoc_q   <= '0;
            misc_q   <= '0;
        end else begin
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rdback_q <= rdback_d;
            tmo_q    <= tmo_d;
            gap_q    <= gap_d;
            pair_q   <= pair_d;
            txn_q    <= txn_d;
            errc_q   <= errc_d;
            tmoc_q   <= tmoc_d;
            misc_q   <= misc_d;
        end
    end

    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = {SW{cyc_q}};
    assign wb_we_o   = we_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign txn_cnt_o = txn_q;
    assign err_cnt_o = errc_q;
    assign tmo_cnt_o = tmoc_q;
    assign mis_cnt_o = misc_q;

endmodule

// File: tb/tb_wb_traffic_gen.sv
module tb_wb_traffic_gen;

    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int WIN = 3;
    localparam int NTX = 60;
    localparam int TMO = 40;
    localparam int CW  = 16;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i;
    logic            start_i;
    logic            rdback_i;
    logic [31:0]     seed_i;
    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic            wb_we_o;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic [DW-1:0]   wb_dat_i;
    logic            wb_ack_i;
    logic            wb_err_i;
    logic            busy_o;
    logic            done_o;
    logic [CW-1:0]   txn_cnt_o;
    logic [CW-1:0]   err_cnt_o;
    logic [CW-1:0]   tmo_cnt_o;
    logic [CW-1:0]   mis_cnt_o;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_traffic_gen #(
        .DW(DW), .AW(AW), .WIN_LOG2(WIN), .NUM_TXN(NTX),
        .TIMEOUT(TMO), .GAP(1), .CW(CW)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start_i),
        .rdback_i(rdback_i), .seed_i(seed_i),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .busy_o(busy_o), .done_o(done_o),
        .txn_cnt_o(txn_cnt_o), .err_cnt_o(err_cnt_o),
        .tmo_cnt_o(tmo_cnt_o), .mis_cnt_o(mis_cnt_o)
    );

    typedef struct {
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic          we;
    } xfer_t;

    xfer_t       exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          mode   = 0;   // 0: silent slave, 1: ack RAM, 2: ack+err on 2nd write
    bit          stuck  = 0;   // bit 0 of word 5 stuck at 0
    bit          len_chk = 0;
    bit          cyc_prev = 0;
    int          cyc_len = 0;
    int          wr_seen = 0;
    logic [31:0] mem [0:(1<<AW)-1];

    function automatic logic [31:0] ref_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Reference run: expected bus transfers go to the scoreboard; returns
    // the expected read-back mismatch count for a stuck word 5.
    task automatic push_run(input logic [31:0] seed, input bit rd, input int err_txn,
                            input bit stk, output int mis);
        logic [31:0] s, a, d;
        xfer_t e;
        mis = 0;
        s = (seed == 32'h0) ? 32'h1 : seed;
        for (int i = 0; i < NTX; i++) begin
            a = ref_next(s);
            d = ref_next(a);
            s = d;
            e.adr = '0;
            e.adr[WIN-1:0] = a[WIN-1:0];
            e.dat = d;
            e.we  = 1'b1;
            exp_q.push_back(e);
            if (rd && i != err_txn) begin
                e.we = 1'b0;
                exp_q.push_back(e);
                if (stk && e.adr == 5 && d[0]) mis++;
            end
        end
    endtask

    // One negedge: monitor the bus against the scoreboard, then drive the slave.
    task automatic bus_cycle();
        xfer_t e;
        if (wb_cyc_o && !cyc_prev) begin
            cyc_len = 1;
            if (wb_we_o) wr_seen++;
            checks++;
            if (wb_stb_o !== 1'b1 || wb_sel_o !== 4'hF) begin
                errors++;
                $display("FAIL strobe_sel: stb=%b sel=%h, required stb=1 sel=f", wb_stb_o, wb_sel_o);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected: adr=%0d we=%b, required no transfer", wb_adr_o, wb_we_o);
            end else begin
                e = exp_q.pop_front();
                if (wb_adr_o !== e.adr || wb_we_o !== e.we || (e.we && wb_dat_o !== e.dat)) begin
                    errors++;
                    $display("FAIL xfer: adr=%0d we=%b dat=%h, required adr=%0d we=%b dat=%h",
                             wb_adr_o, wb_we_o, wb_dat_o, e.adr, e.we, e.dat);
                end
            end
        end else if (wb_cyc_o) begin
            cyc_len++;
        end else if (cyc_prev && len_chk) begin
            checks++;
            if (cyc_len != TMO) begin
                errors++;
                $display("FAIL cyc_length: got %0d cycles, required %0d", cyc_len, TMO);
            end
        end
        cyc_prev = wb_cyc_o;

        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        if (wb_cyc_o && mode != 0) begin
            if (mode == 2 && wb_we_o && wr_seen == 2) begin
                wb_ack_i = 1'b1;
                wb_err_i = 1'b1;
            end else begin
                wb_ack_i = 1'b1;
                if (wb_we_o)
                    mem[wb_adr_o] = (stuck && wb_adr_o == 5) ? {wb_dat_o[31:1], 1'b0} : wb_dat_o;
                else
                    wb_dat_i = mem[wb_adr_o];
            end
        end
    endtask

    task automatic start_run(input logic [31:0] seed, input bit rd);
        @(negedge wb_clk_i);
        bus_cycle();
        seed_i   = seed;
        rdback_i = rd;
        start_i  = 1'b1;
        wr_seen  = 0;
        @(negedge wb_clk_i);
        bus_cycle();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        bit ok;
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge wb_clk_i);
            bus_cycle();
            if (done_o === 1'b1) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL done_wait: done_o not seen within %0d cycles, required done_o=1", limit);
        end
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1; start_i = 1'b0; rdback_i = 1'b0; seed_i = '0;
        wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        repeat (3) @(negedge wb_clk_i);
        checks++;
        if ({wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, busy_o, done_o,
             txn_cnt_o, err_cnt_o, tmo_cnt_o, mis_cnt_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: cyc=%b busy=%b done=%b adr=%0d txn=%0d, required all 0",
                     wb_cyc_o, busy_o, done_o, wb_adr_o, txn_cnt_o);
        end
        wb_rst_i = 1'b0;
    endtask

    task automatic check_counts(input string name, input int txn, input int er, input int tm, input int mi);
        checks++;
        if (txn_cnt_o !== CW'(txn) || err_cnt_o !== CW'(er) || tmo_cnt_o !== CW'(tm) ||
            mis_cnt_o !== CW'(mi) || done_o !== 1'b1 || busy_o !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: txn=%0d err=%0d tmo=%0d mis=%0d done=%b busy=%b left=%0d, required %0d/%0d/%0d/%0d done=1 busy=0 left=0",
                     name, txn_cnt_o, err_cnt_o, tmo_cnt_o, mis_cnt_o, done_o, busy_o, exp_q.size(),
                     txn, er, tm, mi);
        end
    endtask

    task automatic test_ack_run();
        int m;
        mode = 1; stuck = 0;
        push_run(32'h1, 0, -1, 0, m);
        start_run(32'h1, 0);
        wait_done(1000);
        check_counts("ack_run", NTX, 0, 0, 0);
    endtask

    task automatic test_timeout();
        int m;
        mode = 0; len_chk = 1;
        push_run(32'hABCD_1234, 0, -1, 0, m);
        start_run(32'hABCD_1234, 0);
        wait_done(4000);
        len_chk = 0;
        check_counts("timeout_run", NTX, 0, NTX, 0);
    endtask

    task automatic test_err();
        int m;
        mode = 2; stuck = 0;
        push_run(32'h0000_5EED, 1, 1, 0, m);
        start_run(32'h0000_5EED, 1);
        wait_done(1500);
        check_counts("err_run", NTX, 1, 0, 0);
    endtask

    task automatic test_stuck();
        int m;
        mode = 1; stuck = 1;
        push_run(32'h1234_5678, 1, -1, 1, m);
        start_run(32'h1234_5678, 1);
        wait_done(1500);
        check_counts("stuck_run", NTX, 0, 0, m);
        stuck = 0;
    endtask

    task automatic test_reset_mid();
        int m;
        bit seen;
        mode = 0;
        push_run(32'h0000_CAFE, 0, -1, 0, m);
        start_run(32'h0000_CAFE, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge wb_clk_i);
            bus_cycle();
            seen = wb_cyc_o;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_mid_cyc: cyc never rose, required cyc=1");
        end
        repeat (5) begin @(negedge wb_clk_i); bus_cycle(); end
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        bus_cycle();
        checks++;
        if ({wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, busy_o, done_o,
             txn_cnt_o, err_cnt_o, tmo_cnt_o, mis_cnt_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid: cyc=%b busy=%b adr=%0d dat=%h, required all 0",
                     wb_cyc_o, busy_o, wb_adr_o, wb_dat_o);
        end
        wb_rst_i = 1'b0;
        exp_q.delete();
        wb_ack_i = 1'b1; wb_err_i = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        checks++;
        if (wb_cyc_o !== 1'b0 || busy_o !== 1'b0 || txn_cnt_o !== '0 || err_cnt_o !== '0) begin
            errors++;
            $display("FAIL late_ack: cyc=%b busy=%b txn=%0d err=%0d, required 0/0/0/0",
                     wb_cyc_o, busy_o, txn_cnt_o, err_cnt_o);
        end
        mode = 1;
        push_run(32'h1, 0, -1, 0, m);
        start_run(32'h1, 0);
        wait_done(1000);
        check_counts("after_reset_run", NTX, 0, 0, 0);
    endtask

    task automatic test_start_held();
        int m;
        mode = 1;
        push_run(32'h0, 0, -1, 0, m);
        push_run(32'h0, 0, -1, 0, m);
        @(negedge wb_clk_i);
        bus_cycle();
        seed_i = 32'h0; rdback_i = 1'b0; start_i = 1'b1; wr_seen = 0;
        wait_done(1000);
        checks++;
        if (txn_cnt_o !== CW'(NTX) || exp_q.size() != NTX) begin
            errors++;
            $display("FAIL held_first_run: txn=%0d left=%0d, required txn=%0d left=%0d",
                     txn_cnt_o, exp_q.size(), NTX, NTX);
        end
        @(negedge wb_clk_i);
        bus_cycle();
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL held_restart: done=%b busy=%b, required done=0 busy=1", done_o, busy_o);
        end
        start_i = 1'b0;
        wait_done(1000);
        check_counts("held_second_run", NTX, 0, 0, 0);
        repeat (4) begin @(negedge wb_clk_i); bus_cycle(); end
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || wb_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL done_hold: done=%b busy=%b cyc=%b, required 1/0/0", done_o, busy_o, wb_cyc_o);
        end
    endtask

    initial begin
        test_reset();
        test_ack_run();
        test_timeout();
        test_err();
        test_stuck();
        test_reset_mid();
        test_start_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
